// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: a - b computed LSB-first as a + ~b + 1
// through one full-adder slice with a registered carry, launched by start/done.
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] ar_q,     ar_d;
    logic [WIDTH-1:0] br_q,     br_d;
    logic [WIDTH-1:0] sr_q,     sr_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;

    logic sum_bit;
    logic carry_out;

    assign sum_bit   = ar_q[0] ^ br_q[0] ^ carry_q;
    assign carry_out = (ar_q[0] & br_q[0]) | (ar_q[0] & carry_q) | (br_q[0] & carry_q);

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        br_d     = br_q;
        sr_d     = sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ar_d    = a;
                    br_d    = ~b;
                    sr_d    = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                ar_d             = ar_q >> 1;
                br_d             = br_q >> 1;
                sr_d             = sr_q >> 1;
                sr_d[WIDTH-1]    = sum_bit;
                carry_d          = carry_out;
                cnt_d            = cnt_q + CW'(1);
                // carry_q here is the carry into the MSB, needed for signed overflow
                if (cnt_q == LAST_BIT) begin
                    diff_d   = sr_d;
                    borrow_d = ~carry_out;
                    ovf_d    = carry_q ^ carry_out;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ar_q     <= '0;
            br_q     <= '0;
            sr_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            br_q     <= br_d;
            sr_q     <= sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8): latency, results, operand capture,
// mid-run reset and back-to-back issue.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       overflow;

    int unsigned n_checks;
    int unsigned n_fails;

    serial_sub #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done; check latency and results.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_diff, input logic exp_borrow,
                          input logic exp_ovf);
        int unsigned n;
        int unsigned busy_cycles;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'hA5;
        b = 8'h5A;
        n = 0;
        busy_cycles = 0;
        while (!done && n < 20) begin
            if (busy) busy_cycles++;
            tick();
            n++;
        end
        check_eq("latency", n, 32'd8);
        check_eq("busy_cycles", busy_cycles, 32'd8);
        check_eq("diff", 32'(diff), 32'(exp_diff));
        check_eq("borrow", 32'(borrow), 32'(exp_borrow));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        check_eq("busy_at_done", 32'(busy), 32'd0);
        tick();
        check_eq("done_pulse_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int unsigned n;
        int unsigned dones;
        n_checks = 0;
        n_fails  = 0;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h01;
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_borrow", 32'(borrow), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Operand changes and start pulses during RUN must be ignored.
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            if (n == 2) begin
                a = 8'hFF;
                b = 8'h12;
                start = 1'b1;
            end else if (n == 4) begin
                start = 1'b0;
            end
            if (n == 3) check_eq("diff_held_in_run", 32'(diff), 32'h80);
            tick();
            n++;
        end
        check_eq("midrun_latency", n, 32'd8);
        check_eq("midrun_diff", 32'(diff), 32'h02);
        check_eq("midrun_borrow", 32'(borrow), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        check_eq("midrun_no_second_done", dones, 32'd0);

        // Reset at RUN bit 4 aborts and clears outputs.
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        a = 8'h0A;
        b = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_diff", 32'(diff), 32'd0);
        check_eq("abort_borrow", 32'(borrow), 32'd0);
        check_eq("abort_ovf", 32'(overflow), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        check_eq("abort_no_done", dones, 32'd0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // start held high: done every 9 cycles, prior diff visible during next RUN.
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (1) begin
                tick();
                n++;
                if (k > 0 && n == 4) begin
                    check_eq("b2b_diff_in_run", 32'(diff), 32'h0F);
                    check_eq("b2b_busy_in_run", 32'(busy), 32'd1);
                end
                if (done || n >= 20) break;
            end
            check_eq("b2b_interval", n, (k == 0) ? 32'd8 : 32'd9);
            check_eq("b2b_diff", 32'(diff), 32'h0F);
            check_eq("b2b_done", 32'(done), 32'd1);
        end
        start = 1'b0;
        tick();
        check_eq("b2b_idle_busy", 32'(busy), 32'd0);
        check_eq("b2b_idle_done", 32'(done), 32'd0);
        check_eq("b2b_idle_diff", 32'(diff), 32'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
